// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory bus receiver.
//   state_t          : memory-access sequencer states
//   DATA_W_DEF       : default datapath / memory width
//   TIMEOUT_CYC_DEF  : default request timeout in cycles
//   RW_READ/RW_WRITE : encoding of the R_W control input
package lc3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DATA_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Request timeout counter.
//   clk_sys : system clock
//   rst_b   : asynchronous active-low reset
//   clear   : zero the count (request start)
//   enable  : count this cycle (request in flight)
//   expired : the count reaches TIMEOUT_CYC on this cycle's increment,
//             i.e. this is the TIMEOUT_CYC-th request cycle
module mem_timeout_counter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flagged combinationally in the final request cycle so the sequencer
    // can leave on the same edge that would bring the count to TIMEOUT_CYC.
    assign expired = enable && (count >= CNT_LAST);

endmodule

// File: rtl/mem_bus_receiver.sv
// Receiving end of the LC-3 datapath bus: MAR/MDR registers plus the
// memory read/write handshake back to the control FSM.
//   CLK, RST_N           : clock, asynchronous active-low reset
//   BUS                  : datapath bus value
//   LD_MAR, LD_MDR       : register load strobes
//   MIO_EN, R_W          : memory access enable and direction
//   MAR_OUT, MDR_OUT     : register contents (MDR_OUT feeds GateMDR)
//   R, ERR               : access complete / last access timed out
//   MEM_REQ, MEM_WE      : memory request level and write enable
//   MEM_ADDR, MEM_WDATA  : memory address (MAR) and write data (MDR)
//   MEM_RDATA, MEM_ACK   : memory read data and one-cycle completion
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no access; MAR/MDR loadable from BUS
// ST_READ  | read request in flight, MEM_REQ=1
// ST_WRITE | write request in flight, MEM_REQ=1, MEM_WE=1
// ST_DONE  | access finished, R=1 until MIO_EN drops
module mem_bus_receiver
    import lc3_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] BUS,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MIO_EN,
    input  logic              R_W,
    output logic [DATA_W-1:0] MAR_OUT,
    output logic [DATA_W-1:0] MDR_OUT,
    output logic              R,
    output logic              ERR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK
);

    state_t            state, state_next;
    logic [DATA_W-1:0] mar, mdr;
    logic              err;
    logic              start_req;
    logic              rd_done;
    logic              timed_out;
    logic              in_req;
    logic              expired;

    assign in_req = (state == ST_READ) || (state == ST_WRITE);

    mem_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_sys (CLK),
        .rst_b   (RST_N),
        .clear   (start_req),
        .enable  (in_req),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ACK is checked before expiry so an ACK on the last allowed cycle
    // still completes as a success.
    always_comb begin
        state_next = state;
        start_req  = 1'b0;
        rd_done    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MIO_EN) begin
                    if (R_W == RW_WRITE) begin
                        state_next = ST_WRITE;
                        start_req  = 1'b1;
                    end else if (LD_MDR) begin
                        state_next = ST_READ;
                        start_req  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (MEM_ACK) begin
                    state_next = ST_DONE;
                    rd_done    = 1'b1;
                end else if (expired) begin
                    state_next = ST_DONE;
                    timed_out  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (MEM_ACK) begin
                    state_next = ST_DONE;
                end else if (expired) begin
                    state_next = ST_DONE;
                    timed_out  = 1'b1;
                end
            end
            ST_DONE: begin
                if (!MIO_EN) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus loads are only honoured in IDLE so the address and write data
    // stay stable for the whole memory request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mar <= '0;
            mdr <= '0;
            err <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && LD_MAR) begin
                mar <= BUS;
            end
            if ((state == ST_IDLE) && LD_MDR && !MIO_EN) begin
                mdr <= BUS;
            end else if (rd_done) begin
                mdr <= MEM_RDATA;
            end
            if (start_req) begin
                err <= 1'b0;
            end else if (timed_out) begin
                err <= 1'b1;
            end
        end
    end

    assign MAR_OUT   = mar;
    assign MDR_OUT   = mdr;
    assign MEM_ADDR  = mar;
    assign MEM_WDATA = mdr;
    assign ERR       = err;
    assign R         = (state == ST_DONE);
    assign MEM_REQ   = in_req;
    assign MEM_WE    = (state == ST_WRITE);

endmodule

// File: tb/tb_mem_bus_receiver.sv
module tb_mem_bus_receiver;

    localparam int DW = 16;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [DW-1:0] BUS;
    logic          LD_MAR, LD_MDR, MIO_EN, R_W;
    logic [DW-1:0] MAR_OUT, MDR_OUT;
    logic          R, ERR, MEM_REQ, MEM_WE;
    logic [DW-1:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic          MEM_ACK;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [DW-1:0] mdr;
        logic          err;
        logic [DW-1:0] mar;
    } exp_t;

    exp_t exp_q[$];

    mem_bus_receiver #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BUS       (BUS),
        .LD_MAR    (LD_MAR),
        .LD_MDR    (LD_MDR),
        .MIO_EN    (MIO_EN),
        .R_W       (R_W),
        .MAR_OUT   (MAR_OUT),
        .MDR_OUT   (MDR_OUT),
        .R         (R),
        .ERR       (ERR),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_ACK   (MEM_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic push(input logic [DW-1:0] mdr, input logic err, input logic [DW-1:0] mar);
        exp_t e;
        e.mdr = mdr;
        e.err = err;
        e.mar = mar;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: each rising R is one completed access.
    logic r_seen = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            r_seen = 1'b0;
        end else begin
            if (R && !r_seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_mdr", MDR_OUT, e.mdr);
                    chk("sb_err", ERR, e.err);
                    chk("sb_mar", MAR_OUT, e.mar);
                end
            end
            r_seen = R;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; BUS = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0;
        MEM_RDATA = '0; MEM_ACK = 0;
        step(); step();
        chk("rst_mar", MAR_OUT, 16'h0000);
        chk("rst_mdr", MDR_OUT, 16'h0000);
        chk("rst_r", R, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_req", MEM_REQ, 1'b0);
        chk("rst_we", MEM_WE, 1'b0);
        chk("rst_addr", MEM_ADDR, 16'h0000);
        chk("rst_wdata", MEM_WDATA, 16'h0000);
        RST_N = 1'b1;
        step();

        // Register loads from BUS
        BUS = 16'h3000; LD_MAR = 1;
        step();
        chk("ld_mar", MAR_OUT, 16'h3000);
        chk("ld_mar_addr", MEM_ADDR, 16'h3000);
        LD_MAR = 0; BUS = 16'h1234; LD_MDR = 1;
        step();
        chk("ld_mdr", MDR_OUT, 16'h1234);
        chk("ld_mdr_wdata", MEM_WDATA, 16'h1234);

        // Read, ACK in 4th request cycle
        MIO_EN = 1; R_W = 0; LD_MDR = 1;
        push(16'hBEEF, 1'b0, 16'h3000);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rd_req", MEM_REQ, 1'b1);
            chk("rd_we", MEM_WE, 1'b0);
            chk("rd_r_low", R, 1'b0);
            if (k == 4) begin MEM_ACK = 1; MEM_RDATA = 16'hBEEF; end
        end
        step();
        MEM_ACK = 0; MEM_RDATA = 16'h0000; LD_MDR = 0;
        chk("rd_r", R, 1'b1);
        chk("rd_req_done", MEM_REQ, 1'b0);
        // Handshake: MIO_EN held high, no new request
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_r", R, 1'b1);
            chk("hold_req", MEM_REQ, 1'b0);
        end
        MIO_EN = 0;
        step();
        chk("rd_r_fall", R, 1'b0);
        chk("rd_mdr_kept", MDR_OUT, 16'hBEEF);

        // Write with LD_MAR attempt during request
        BUS = 16'hFE06; LD_MAR = 1;
        step();
        LD_MAR = 0; BUS = 16'hA5A5; LD_MDR = 1;
        step();
        LD_MDR = 0; MIO_EN = 1; R_W = 1;
        push(16'hA5A5, 1'b0, 16'hFE06);
        step();
        LD_MAR = 1; BUS = 16'h0000;
        for (int k = 1; k <= 3; k++) begin
            chk("wr_req", MEM_REQ, 1'b1);
            chk("wr_we", MEM_WE, 1'b1);
            chk("wr_wdata", MEM_WDATA, 16'hA5A5);
            if (k == 3) begin MEM_ACK = 1; MEM_RDATA = 16'h1111; end
            else step();
        end
        step();
        MEM_ACK = 0; LD_MAR = 0;
        chk("wr_r", R, 1'b1);
        chk("wr_we_done", MEM_WE, 1'b0);
        MIO_EN = 0; R_W = 0;
        step();
        chk("wr_mar_stable", MAR_OUT, 16'hFE06);
        chk("wr_mdr_unchanged", MDR_OUT, 16'hA5A5);

        // Read timeout: no ACK for 8 request cycles
        BUS = 16'h5555; MIO_EN = 1; LD_MDR = 1;
        push(16'hA5A5, 1'b1, 16'hFE06);
        for (int k = 1; k <= TO; k++) begin
            step();
            chk("to_req", MEM_REQ, 1'b1);
        end
        step();
        chk("to_r", R, 1'b1);
        chk("to_err", ERR, 1'b1);
        MIO_EN = 0; LD_MDR = 0;
        step();
        chk("to_err_sticky", ERR, 1'b1);
        chk("to_r_fall", R, 1'b0);

        // Next request clears ERR; minimum latency read
        MIO_EN = 1; LD_MDR = 1;
        push(16'h7777, 1'b0, 16'hFE06);
        step();
        chk("min_req", MEM_REQ, 1'b1);
        chk("err_cleared", ERR, 1'b0);
        MEM_ACK = 1; MEM_RDATA = 16'h7777;
        step();
        MEM_ACK = 0;
        chk("min_r", R, 1'b1);
        MIO_EN = 0; LD_MDR = 0;
        step();

        // ACK on the exact expiry cycle counts as success
        MIO_EN = 1; LD_MDR = 1;
        push(16'hCAFE, 1'b0, 16'hFE06);
        for (int k = 1; k <= TO; k++) begin
            step();
            chk("edge_req", MEM_REQ, 1'b1);
            if (k == TO) begin MEM_ACK = 1; MEM_RDATA = 16'hCAFE; end
        end
        step();
        MEM_ACK = 0;
        chk("edge_r", R, 1'b1);
        chk("edge_err", ERR, 1'b0);
        MIO_EN = 0; LD_MDR = 0;
        step();

        // Stray ACK in IDLE
        MEM_ACK = 1; MEM_RDATA = 16'hDEAD;
        step(); step();
        MEM_ACK = 0;
        chk("stray_mdr", MDR_OUT, 16'hCAFE);
        chk("stray_r", R, 1'b0);
        chk("stray_req", MEM_REQ, 1'b0);

        // MIO_EN read without LD_MDR does nothing
        MIO_EN = 1; R_W = 0; LD_MDR = 0;
        step(); step();
        chk("noload_req", MEM_REQ, 1'b0);
        chk("noload_r", R, 1'b0);
        MIO_EN = 0;
        step();

        // Asynchronous reset in the middle of a read
        MIO_EN = 1; LD_MDR = 1;
        step(); step();
        chk("mid_req", MEM_REQ, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_req", MEM_REQ, 1'b0);
        chk("arst_mar", MAR_OUT, 16'h0000);
        chk("arst_mdr", MDR_OUT, 16'h0000);
        chk("arst_r", R, 1'b0);
        MIO_EN = 0; LD_MDR = 0;
        step();
        RST_N = 1'b1;
        step(); step();
        chk("post_rst_req", MEM_REQ, 1'b0);
        chk("post_rst_r", R, 1'b0);
        chk("post_rst_err", ERR, 1'b0);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
